// File: rtl/jtframe_db9_joy_pkg.sv
// Shared constants for the DB9 joystick sequencer/decoder.
// Phase numbers, output bit positions and FSM encoding.
package jtframe_db9_pkg;

  localparam logic [2:0] PH_DIR    = 3'd0;
  localparam logic [2:0] PH_ABS    = 3'd1;
  localparam logic [2:0] PH_DET6   = 3'd5;
  localparam logic [2:0] PH_XYZ    = 3'd6;
  localparam logic [2:0] PH_COMMIT = 3'd7;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_UP    = 3;
  localparam int BIT_B     = 4;
  localparam int BIT_C     = 5;
  localparam int BIT_A     = 6;
  localparam int BIT_X     = 7;
  localparam int BIT_Y     = 8;
  localparam int BIT_Z     = 9;
  localparam int BIT_START = 10;
  localparam int BIT_MODE  = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/jtframe_db9_joy_if.sv
// Pad-side bundle: line sync, both DB9 buses, shared
// SELECT and the two decoded joystick words.
interface jtframe_db9_joy_if;

  logic        hs;
  logic [5:0]  joy1_bus;
  logic [5:0]  joy2_bus;
  logic        JOY_SELECT;
  logic [11:0] joystick1;
  logic [11:0] joystick2;

  modport master (
    output hs, joy1_bus, joy2_bus,
    input  JOY_SELECT, joystick1, joystick2
  );

  modport slave (
    input  hs, joy1_bus, joy2_bus,
    output JOY_SELECT, joystick1, joystick2
  );

endinterface

// File: rtl/jtframe_db9_decode.sv
// Per-port DB9 decoder: builds a shadow word phase by
// phase and publishes it only on the commit phase.
module jtframe_db9_decode
  import jtframe_db9_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        step,
  input  logic [2:0]  phase,
  input  logic [5:0]  bus,
  output logic [11:0] word
);

  logic [11:0] shadow;
  logic        six;

  // Capture pins of the current phase, commit on the last.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      shadow <= '0;
      six    <= 1'b0;
      word   <= '0;
    end else if (step) begin
      unique case (1'b1)
        phase == PH_DIR: begin
          shadow[BIT_UP]    <= ~bus[0];
          shadow[BIT_DOWN]  <= ~bus[1];
          shadow[BIT_LEFT]  <= ~bus[2];
          shadow[BIT_RIGHT] <= ~bus[3];
          shadow[BIT_B]     <= ~bus[4];
          shadow[BIT_C]     <= ~bus[5];
          six               <= 1'b0;
        end
        phase == PH_ABS: begin
          shadow[BIT_A] <=
            (bus[3:2] == 2'b00) & ~bus[4];
          shadow[BIT_START] <=
            (bus[3:2] == 2'b00) & ~bus[5];
        end
        phase == PH_DET6: begin
          if (bus[3:0] == 4'b0000)
            six <= 1'b1;
        end
        phase == PH_XYZ: begin
          shadow[BIT_Z]    <= six & ~bus[0];
          shadow[BIT_Y]    <= six & ~bus[1];
          shadow[BIT_X]    <= six & ~bus[2];
          shadow[BIT_MODE] <= six & ~bus[3];
        end
        phase == PH_COMMIT: begin
          word <= shadow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_db9_joy.sv
// Two-port DB9 pad sequencer: one protocol step per line,
// long SELECT-high idle so 6-button pads time out.
module jtframe_db9_joy
  import jtframe_db9_pkg::*;
#(
  parameter int IDLE_LINES = 32
) (
  input logic               clk_sys,
  input logic               rst,
  jtframe_db9_joy_if.slave  pads
);

  localparam int CW = $clog2(IDLE_LINES + 1);

  logic          hs_l;
  logic          step;
  logic          sample;
  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] idle_nx;
  logic [2:0]    phase;
  logic [2:0]    phase_nx;
  logic [11:0]   word1;
  logic [11:0]   word2;

  // Rising-edge detector on line sync.
  always_ff @(posedge clk_sys) begin
    if (rst) hs_l <= 1'b0;
    else     hs_l <= pads.hs;
  end

  assign step = pads.hs & ~hs_l;

  // Sequencer state registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
      phase    <= PH_DIR;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_nx;
      phase    <= phase_nx;
    end
  end

  // Idle timeout, then eight protocol phases.
  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    phase_nx = phase;
    if (step) begin
      unique case (state)
        IDLE: begin
          if (idle_cnt == CW'(IDLE_LINES - 1)) begin
            state_nx = RUN;
            phase_nx = PH_DIR;
          end else begin
            idle_nx = idle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (phase == PH_COMMIT) begin
            state_nx = IDLE;
            idle_nx  = '0;
            phase_nx = PH_DIR;
          end else begin
            phase_nx = phase + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sample = step & (state == RUN);

  assign pads.JOY_SELECT =
    (state == IDLE) | ~phase[0];

  jtframe_db9_decode u_dec1 (
    .clk_sys (clk_sys),
    .rst     (rst),
    .step    (sample),
    .phase   (phase),
    .bus     (pads.joy1_bus),
    .word    (word1)
  );

  jtframe_db9_decode u_dec2 (
    .clk_sys (clk_sys),
    .rst     (rst),
    .step    (sample),
    .phase   (phase),
    .bus     (pads.joy2_bus),
    .word    (word2)
  );

  assign pads.joystick1 = word1;
  assign pads.joystick2 = word2;

endmodule

// File: tb/tb_jtframe_db9_joy.sv
// Bench for jtframe_db9_joy: behavioural pad models,
// scoreboard of expected words, commit-time monitor.
module tb_jtframe_db9_joy;

  localparam int P_NONE  = 0;
  localparam int P_ATARI = 1;
  localparam int P_MD3   = 2;
  localparam int P_MD6   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs  = 1'b0;

  int          t1 = P_NONE;
  int          t2 = P_NONE;
  logic [11:0] b1 = '0;
  logic [11:0] b2 = '0;
  int          fcnt = 0;
  int          hi = 0;
  logic        sel_q = 1'b1;
  logic        hs_q = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [23:0] sb[$];
  logic [11:0] cur1 = '0;
  logic [11:0] cur2 = '0;

  jtframe_db9_joy_if bus();

  jtframe_db9_joy #(.IDLE_LINES(32)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .pads    (bus)
  );

  always #5 clk = ~clk;

  // A real pad: what it puts on the pins for its
  // type, held buttons, SELECT and SELECT-low count.
  function automatic logic [5:0] pad_bus(
    input int t, input logic [11:0] b,
    input logic sel, input int fc);
    logic six;
    six = (t == P_MD6) && (fc == 3);
    case (t)
      P_ATARI:
        return ~{b[5], b[4], b[0], b[1], b[2], b[3]};
      P_MD3, P_MD6:
        if (sel)
          return six ?
            ~{b[5], b[4], b[11], b[7], b[8], b[9]} :
            ~{b[5], b[4], b[0], b[1], b[2], b[3]};
        else
          return six ?
            ~{b[10], b[6], 4'hF} :
            ~{b[10], b[6], 2'b11, b[2], b[3]};
      default:
        return 6'h3F;
    endcase
  endfunction

  // What the decoded word must be for a pad type.
  function automatic logic [11:0] exp_word(
    input int t, input logic [11:0] b);
    case (t)
      P_ATARI: return b & 12'h03F;
      P_MD3:   return b & 12'h47F;
      P_MD6:   return b;
      default: return 12'h000;
    endcase
  endfunction

  // Physical stick: no opposing directions at once.
  function automatic logic [11:0] rnd_btn();
    logic [11:0] r;
    r = 12'($urandom);
    if (r[0] && r[1]) r[1] = 1'b0;
    if (r[2] && r[3]) r[2] = 1'b0;
    return r;
  endfunction

  assign bus.hs = hs;
  assign bus.joy1_bus = pad_bus(t1, b1, bus.JOY_SELECT, fcnt);
  assign bus.joy2_bus = pad_bus(t2, b2, bus.JOY_SELECT, fcnt);

  // Pad-internal counter: counts SELECT lows, times out
  // after SELECT stays high for several lines.
  always @(posedge clk) begin
    sel_q <= bus.JOY_SELECT;
    hs_q  <= hs;
    if (sel_q && !bus.JOY_SELECT) fcnt <= fcnt + 1;
    if (hs && !hs_q) begin
      if (bus.JOY_SELECT) begin
        if (hi < 100) hi <= hi + 1;
        if (hi >= 4) fcnt <= 0;
      end else begin
        hi <= 0;
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h",
               name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse();
    hs = 1'b1;
    repeat (3) tick();
    hs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push_exp();
    cur1 = exp_word(t1, b1);
    cur2 = exp_word(t2, b2);
    sb.push_back({cur1, cur2});
  endtask

  task automatic run_cycle(input bit chk_sel,
                           input int chg_at);
    logic e;
    push_exp();
    for (int k = 1; k <= 40; k++) begin
      pulse();
      if (chk_sel) begin
        e = (k <= 32 || k == 40) ? 1'b1 :
            (((k - 32) % 2) == 0);
        check($sformatf("sel_edge%0d", k),
              32'(bus.JOY_SELECT), 32'(e));
      end
      if (k == chg_at) begin
        b1 = rnd_btn();
        b2 = rnd_btn();
      end
    end
  endtask

  // Monitor: a commit is the SELECT rise after the
  // fourth SELECT fall; outputs may change only then.
  initial begin
    int          falls;
    logic        msel;
    logic [11:0] mj1;
    logic [11:0] mj2;
    logic [23:0] e;
    falls = 0;
    msel = 1'b1;
    mj1 = '0;
    mj2 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        falls = 0;
        msel = 1'b1;
        mj1 = bus.joystick1;
        mj2 = bus.joystick2;
      end else begin
        if (msel && !bus.JOY_SELECT) falls++;
        if (!msel && bus.JOY_SELECT && falls == 4) begin
          falls = 0;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("joystick1", 32'(bus.joystick1),
                  32'(e[23:12]));
            check("joystick2", 32'(bus.joystick2),
                  32'(e[11:0]));
          end
        end else if (bus.joystick1 !== mj1 ||
                     bus.joystick2 !== mj2) begin
          check("atomic", {8'h0, bus.joystick1,
                bus.joystick2}, {8'h0, mj1, mj2});
        end
        msel = bus.JOY_SELECT;
        mj1 = bus.joystick1;
        mj2 = bus.joystick2;
      end
    end
  end

  initial begin
    int n;
    logic [11:0] p1;
    logic [11:0] p2;

    repeat (3) tick();
    check("rst_sel", 32'(bus.JOY_SELECT), 32'd1);
    check("rst_j1", 32'(bus.joystick1), 32'd0);
    check("rst_j2", 32'(bus.joystick2), 32'd0);
    rst = 1'b0;
    tick();

    t1 = P_NONE; t2 = P_NONE;
    run_cycle(1'b1, 0);

    t1 = P_ATARI; b1 = 12'h018;
    t2 = P_NONE;  b2 = 12'h000;
    run_cycle(1'b0, 0);

    t1 = P_ATARI; b1 = rnd_btn();
    t2 = P_MD3;   b2 = 12'h448;
    run_cycle(1'b0, 0);

    t1 = P_MD6;   b1 = 12'h891;
    t2 = P_ATARI; b2 = 12'h021;
    run_cycle(1'b0, 0);

    t1 = P_ATARI; b1 = rnd_btn();
    t2 = P_ATARI; b2 = rnd_btn();
    run_cycle(1'b0, 35);

    for (int i = 0; i < 12; i++) begin
      t1 = int'($urandom_range(0, 3));
      t2 = int'($urandom_range(0, 3));
      b1 = rnd_btn();
      b2 = rnd_btn();
      run_cycle(1'b0, 0);
    end

    p1 = cur1;
    p2 = cur2;
    t1 = P_MD6; b1 = rnd_btn();
    t2 = P_MD3; b2 = rnd_btn();
    push_exp();
    for (int k = 0; k < 37; k++) pulse();
    repeat (100) tick();
    check("frozen_sel", 32'(bus.JOY_SELECT), 32'd0);
    check("frozen_j1", 32'(bus.joystick1), 32'(p1));
    check("frozen_j2", 32'(bus.joystick2), 32'(p2));
    for (int k = 0; k < 3; k++) pulse();

    t1 = P_MD6; b1 = rnd_btn();
    t2 = P_MD6; b2 = rnd_btn();
    push_exp();
    for (int k = 0; k < 36; k++) pulse();
    rst = 1'b1;
    tick();
    check("mid_rst_sel", 32'(bus.JOY_SELECT), 32'd1);
    check("mid_rst_j1", 32'(bus.joystick1), 32'd0);
    check("mid_rst_j2", 32'(bus.joystick2), 32'd0);
    sb.delete();
    rst = 1'b0;
    tick();
    push_exp();
    n = 0;
    do begin
      pulse();
      n++;
    end while (bus.JOY_SELECT && n < 60);
    check("rst_to_fall", 32'(n), 32'd33);
    for (int k = 0; k < 7; k++) pulse();

    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
